// File: rtl/ctrl_seq.sv
// ctrl_seq: sequenced control unit. It decodes the instruction word into datapath controls
// and runs the program lifecycle (Start/Ack), multi-cycle loads, stalls and instruction
// retirement counting.
// Optional build macro CTRL_SEQ_PERF_CNT_EN adds the active-cycle counter on CycleCount;
// without it CycleCount is tied to zero.
module ctrl_seq #(
  parameter int unsigned IW       = 9,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic [IW-1:0]    Instruction,
  output logic             PcAdv,
  output logic             Jump,
  output logic             BranchEn,
  output logic             RegWrEn,
  output logic             MemWrEn,
  output logic             LoadInst,
  output logic             RegDst,
  output logic             Ack,
  output logic [1:0]       AInSel,
  output logic [1:0]       BInSel,
  output logic [3:0]       ALUOp,
  output logic [CNT_W-1:0] InstCount,
  output logic [CNT_W-1:0] CycleCount
);

  localparam int unsigned WaitW = 4;
  localparam logic [3:0] OpAdd = 4'b0000;

  typedef enum logic [1:0] {StIdle, StRun, StMemWait, StDone} state_e;

  state_e             r_state;
  logic [WaitW-1:0]   r_wait;
  logic               r_ack;
  logic [CNT_W-1:0]   r_inst_cnt;

  logic [1:0]         w_t;
  logic [3:0]         w_funct;
  logic [IW-7:0]      w_low;
  logic               w_is_ack;
  logic               w_is_load;

  assign w_t       = Instruction[IW-1 -: 2];
  assign w_funct   = Instruction[IW-3 -: 4];
  assign w_low     = Instruction[IW-7:0];
  assign w_is_ack  = (w_t == 2'b10) && (w_funct == 4'b1111) && (&w_low);
  assign w_is_load = (w_t == 2'b10) && (w_funct == 4'b0010);

  // Decode datapath controls from the current state and instruction word.
  always_comb begin
    PcAdv    = 1'b0;
    Jump     = 1'b0;
    BranchEn = 1'b0;
    RegWrEn  = 1'b0;
    MemWrEn  = 1'b0;
    LoadInst = 1'b0;
    RegDst   = 1'b0;
    AInSel   = 2'd0;
    BInSel   = 2'd0;
    ALUOp    = OpAdd;
    unique case (r_state)
      StRun: begin
        if (!Stall && !w_is_ack) begin
          PcAdv = 1'b1;
          if (!w_t[1]) begin
            RegWrEn = 1'b1;
            AInSel  = 2'd2;
          end else if (w_t[0]) begin
            BranchEn = 1'b1;
            Jump     = w_funct[3];
          end else begin
            unique case (w_funct)
              4'b0000, 4'b0001, 4'b0101, 4'b0110, 4'b0111,
              4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: begin
                RegWrEn = 1'b1;
                AInSel  = 2'd1;
                BInSel  = 2'd1;
                ALUOp   = w_funct;
              end
              4'b0010: begin
                LoadInst = 1'b1;
                // Single-cycle loads write back now; longer ones hold fetch until MEM_WAIT ends.
                if (LOAD_LAT == 1) begin
                  RegWrEn = 1'b1;
                end else begin
                  PcAdv = 1'b0;
                end
              end
              4'b0011: MemWrEn = 1'b1;
              4'b0100: begin
                RegWrEn = 1'b1;
                RegDst  = 1'b1;
                BInSel  = 2'd1;
              end
              default: ;
            endcase
          end
        end
      end
      StMemWait: begin
        LoadInst = 1'b1;
        if (!Stall && (r_wait == WaitW'(1))) begin
          RegWrEn = 1'b1;
          PcAdv   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Lifecycle FSM, load wait counter, Ack and retired-instruction counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_wait     <= '0;
      r_ack      <= 1'b0;
      r_inst_cnt <= '0;
    end else begin
      if (PcAdv && (r_inst_cnt != {CNT_W{1'b1}})) begin
        r_inst_cnt <= r_inst_cnt + CNT_W'(1);
      end
      unique case (r_state)
        StIdle, StDone: begin
          if (Start) begin
            r_state    <= StRun;
            r_ack      <= 1'b0;
            r_inst_cnt <= '0;
          end
        end
        StRun: begin
          if (!Stall) begin
            if (w_is_ack) begin
              r_state <= StDone;
              r_ack   <= 1'b1;
            end else if (w_is_load && (LOAD_LAT > 1)) begin
              r_state <= StMemWait;
              r_wait  <= WaitW'(LOAD_LAT - 1);
            end
          end
        end
        StMemWait: begin
          if (!Stall) begin
            if (r_wait > WaitW'(1)) begin
              r_wait <= r_wait - WaitW'(1);
            end else begin
              r_state <= StRun;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Ack       = r_ack;
  assign InstCount = r_inst_cnt;

`ifdef CTRL_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  // Active-cycle counter: RUN and MEM_WAIT cycles, stalls included, saturating.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cycle_cnt <= '0;
    end else if (((r_state == StIdle) || (r_state == StDone)) && Start) begin
      r_cycle_cnt <= '0;
    end else if (((r_state == StRun) || (r_state == StMemWait)) &&
                 (r_cycle_cnt != {CNT_W{1'b1}})) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign CycleCount = r_cycle_cnt;
`else
  assign CycleCount = '0;
`endif

endmodule
